// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode-side, alu_32-side and writeback-side signals of the ALU issue controller
interface alu_issue_ctrl_if #(
  parameter int WORD_SIZE = 32,
  parameter int CONTROL_SIGNAL_SIZE = 4,
  parameter int EXC_COUNT_WIDTH = 16
);
  logic in_valid;
  logic in_ready;
  logic [5:0] in_opcode;
  logic [5:0] in_funct;
  logic [WORD_SIZE-1:0] in_rs_val;
  logic [WORD_SIZE-1:0] in_rt_val;
  logic [15:0] in_imm;
  logic [WORD_SIZE-1:0] alu_input_a;
  logic [WORD_SIZE-1:0] alu_input_b;
  logic [CONTROL_SIGNAL_SIZE-1:0] alu_control;
  logic [WORD_SIZE-1:0] alu_result;
  logic alu_zero;
  logic alu_err_overflow;
  logic alu_err_invalid_control;
  logic out_valid;
  logic out_ready;
  logic [WORD_SIZE-1:0] out_result;
  logic out_branch_taken;
  logic out_exc_overflow;
  logic out_exc_invalid;
  logic [EXC_COUNT_WIDTH-1:0] exc_count;
  modport slave (
    input in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
    input alu_result, alu_zero, alu_err_overflow, alu_err_invalid_control, out_ready,
    output in_ready, alu_input_a, alu_input_b, alu_control,
    output out_valid, out_result, out_branch_taken, out_exc_overflow, out_exc_invalid, exc_count
  );
  modport master (
    output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
    output alu_result, alu_zero, alu_err_overflow, alu_err_invalid_control, out_ready,
    input in_ready, alu_input_a, alu_input_b, alu_control,
    input out_valid, out_result, out_branch_taken, out_exc_overflow, out_exc_invalid, exc_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes MIPS instructions, drives alu_32 for one cycle and returns one flagged response each
module alu_issue_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int CONTROL_SIGNAL_SIZE = 4,
  parameter int EXC_COUNT_WIDTH = 16
) (
  input logic clock,
  input logic reset_n,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic [WORD_SIZE-1:0] r_a, r_b, r_result, w_b, w_sext, w_zext;
  logic [CONTROL_SIGNAL_SIZE-1:0] r_ctrl, w_ctrl;
  logic [EXC_COUNT_WIDTH-1:0] r_exc_count;
  logic r_ovf_en, r_beq, r_branch, r_exc_ovf, r_exc_inv;
  logic w_dec_ok, w_ovf_en, w_beq, w_accept, w_done, w_alu_inv;
  assign w_sext = {{(WORD_SIZE-16){bus.in_imm[15]}}, bus.in_imm};
  assign w_zext = {{(WORD_SIZE-16){1'b0}}, bus.in_imm};
  always_comb begin
    w_dec_ok = 1'b1;
    w_ctrl = '0;
    w_b = w_sext;
    w_ovf_en = 1'b0;
    w_beq = 1'b0;
    case (bus.in_opcode)
      6'h00: begin
        w_b = bus.in_rt_val;
        case (bus.in_funct)
          6'h20: begin w_ctrl = 4'h2; w_ovf_en = 1'b1; end
          6'h21: w_ctrl = 4'h3;
          6'h22: begin w_ctrl = 4'h6; w_ovf_en = 1'b1; end
          6'h23: w_ctrl = 4'h6;
          6'h24: w_ctrl = 4'h0;
          6'h25: w_ctrl = 4'h1;
          6'h27: w_ctrl = 4'hC;
          6'h2A: w_ctrl = 4'h7;
          default: w_dec_ok = 1'b0;
        endcase
      end
      6'h08: begin w_ctrl = 4'h2; w_ovf_en = 1'b1; end
      6'h09: w_ctrl = 4'h3;
      6'h0A: w_ctrl = 4'h7;
      6'h0C: begin w_ctrl = 4'h0; w_b = w_zext; end
      6'h0D: begin w_ctrl = 4'h1; w_b = w_zext; end
      6'h23, 6'h2B: w_ctrl = 4'h2;
      6'h04: begin w_ctrl = 4'h6; w_b = bus.in_rt_val; w_beq = 1'b1; end
      default: w_dec_ok = 1'b0;
    endcase
  end
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_done = (r_state == RESP) && bus.out_ready;
  assign w_alu_inv = bus.alu_err_invalid_control;
  always_comb begin
    w_next = r_state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = w_dec_ok ? EXEC : RESP;
      end
      EXEC: w_next = RESP;
      RESP: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_ctrl <= '0;
      r_ovf_en <= 1'b0;
      r_beq <= 1'b0;
      r_result <= '0;
      r_branch <= 1'b0;
      r_exc_ovf <= 1'b0;
      r_exc_inv <= 1'b0;
      r_exc_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a <= bus.in_rs_val;
        r_b <= w_b;
        r_ctrl <= w_ctrl;
        r_ovf_en <= w_ovf_en;
        r_beq <= w_beq;
        r_result <= '0;
        r_branch <= 1'b0;
        r_exc_ovf <= 1'b0;
        r_exc_inv <= !w_dec_ok;
      end
      if (r_state == EXEC) begin
        r_result <= w_alu_inv ? '0 : bus.alu_result;
        r_branch <= r_beq && bus.alu_zero && !w_alu_inv;
        r_exc_ovf <= r_ovf_en && bus.alu_err_overflow && !w_alu_inv;
        r_exc_inv <= w_alu_inv;
      end
      if (w_done && (r_exc_ovf || r_exc_inv) && !(&r_exc_count))
        r_exc_count <= r_exc_count + EXC_COUNT_WIDTH'(1);
    end
  end
  assign bus.alu_input_a = r_a;
  assign bus.alu_input_b = r_b;
  assign bus.alu_control = r_ctrl;
  assign bus.out_result = r_result;
  assign bus.out_branch_taken = r_branch;
  assign bus.out_exc_overflow = r_exc_ovf;
  assign bus.out_exc_invalid = r_exc_inv;
  assign bus.exc_count = r_exc_count;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table, hand sequences and random traffic against an instruction-level model
module tb_alu_issue_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  alu_issue_ctrl_if bus();
  alu_issue_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;
  logic force_inv = 1'b0;
  logic [31:0] a, b, alu_res;
  logic alu_ov, alu_ic;
  assign a = bus.alu_input_a;
  assign b = bus.alu_input_b;
  always_comb begin
    alu_res = '0;
    alu_ov = 1'b0;
    alu_ic = 1'b0;
    case (bus.alu_control)
      4'h0: alu_res = a & b;
      4'h1: alu_res = a | b;
      4'h2, 4'h3: begin alu_res = a + b; alu_ov = (a[31] == b[31]) && (alu_res[31] != a[31]); end
      4'h6: begin alu_res = a - b; alu_ov = (a[31] != b[31]) && (alu_res[31] != a[31]); end
      4'h7: alu_res = {31'b0, $signed(a) < $signed(b)};
      4'hC: alu_res = ~(a | b);
      default: alu_ic = 1'b1;
    endcase
    if (force_inv) begin
      alu_ic = 1'b1;
      alu_ov = 1'b0;
      alu_res = 32'hDEADBEEF;
    end
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero = (alu_res == 32'h0);
  assign bus.alu_err_overflow = alu_ov;
  assign bus.alu_err_invalid_control = alu_ic;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic void ref_model(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                                    input logic [31:0] rt, input logic [15:0] imm, output logic [31:0] res,
                                    output logic br, output logic ov, output logic inv);
    longint srs, srt, ssx;
    logic [31:0] sx, zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0, imm};
    srs = longint'($signed(rs));
    srt = longint'($signed(rt));
    ssx = longint'($signed(sx));
    res = '0; br = 1'b0; ov = 1'b0; inv = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: begin res = rs + rt; ov = ovf(srs + srt); end
        6'h21: res = rs + rt;
        6'h22: begin res = rs - rt; ov = ovf(srs - srt); end
        6'h23: res = rs - rt;
        6'h24: res = rs & rt;
        6'h25: res = rs | rt;
        6'h27: res = ~(rs | rt);
        6'h2A: res = (srs < srt) ? 32'd1 : 32'd0;
        default: inv = 1'b1;
      endcase
      6'h08: begin res = rs + sx; ov = ovf(srs + ssx); end
      6'h09: res = rs + sx;
      6'h0A: res = (srs < ssx) ? 32'd1 : 32'd0;
      6'h0C: res = rs & zx;
      6'h0D: res = rs | zx;
      6'h23, 6'h2B: res = rs + sx;
      6'h04: begin res = rs - rt; br = (rs == rt); end
      default: inv = 1'b1;
    endcase
  endfunction

  task automatic xact(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, input int hold, output logic [31:0] res, output logic br,
                      output logic ov, output logic inv, output int lat);
    int t;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clock); t++; end
    bus.in_valid = 1'b1;
    bus.in_opcode = op; bus.in_funct = fn; bus.in_rs_val = rs; bus.in_rt_val = rt; bus.in_imm = imm;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_opcode = 6'($urandom); bus.in_funct = 6'($urandom);
    bus.in_rs_val = $urandom; bus.in_rt_val = $urandom; bus.in_imm = 16'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(negedge clock); lat++; end
    res = bus.out_result; br = bus.out_branch_taken; ov = bus.out_exc_overflow; inv = bus.out_exc_invalid;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("hold_result", bus.out_result, res);
      chk("hold_flags", {29'b0, bus.out_branch_taken, bus.out_exc_overflow, bus.out_exc_invalid}, {29'b0, br, ov, inv});
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [5:0] op, fn;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [31:0] res;
    logic br, ov, inv;
  } vec_t;
  vec_t tbl[16];
  logic [11:0] rops[19] = '{
    {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25},
    {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h0A, 6'h00}, {6'h0C, 6'h00},
    {6'h0D, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h3F, 6'h00}, {6'h00, 6'h26},
    {6'h0E, 6'h00}
  };

  initial begin
    logic [31:0] r, er, rs, rt;
    logic g_br, g_ov, g_inv, e_br, e_ov, e_inv;
    logic [5:0] op, fn;
    logic [15:0] imm;
    int lat;
    tbl[0]  = '{6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h80000000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{6'h09, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h0001, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8000, 32'h00008000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{6'h08, 6'h00, 32'h0, 32'h0, 16'h8000, 32'hFFFF8000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{6'h04, 6'h00, 32'h5, 32'h5, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{6'h04, 6'h00, 32'h5, 32'h6, 16'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0, 32'h1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{6'h3F, 6'h00, 32'h1234, 32'h5678, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{6'h00, 6'h22, 32'h80000000, 32'h1, 16'h0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{6'h00, 6'h23, 32'h80000000, 32'h1, 16'h0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{6'h00, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 16'h0, 32'h00000F0F, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{6'h0D, 6'h00, 32'h12340000, 32'h0, 16'hABCD, 32'h1234ABCD, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{6'h23, 6'h00, 32'h1000, 32'h0, 16'hFFFC, 32'h00000FFC, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{6'h00, 6'h3F, 32'h1, 32'h2, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{6'h0A, 6'h00, 32'h5, 32'h0, 16'hFFFF, 32'h0, 1'b0, 1'b0, 1'b0};
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_opcode = '0; bus.in_funct = '0; bus.in_rs_val = '0; bus.in_rt_val = '0; bus.in_imm = '0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_alu_a", bus.alu_input_a, 32'h0);
    chk("rst_alu_b", bus.alu_input_b, 32'h0);
    chk("rst_alu_ctrl", {28'b0, bus.alu_control}, 32'h0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_flags", {29'b0, bus.out_branch_taken, bus.out_exc_overflow, bus.out_exc_invalid}, 32'h0);
    chk("rst_exc_count", {16'b0, bus.exc_count}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      xact(tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].imm, 0, r, g_br, g_ov, g_inv, lat);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
      chk($sformatf("tbl%0d_flags", i), {29'b0, g_br, g_ov, g_inv}, {29'b0, tbl[i].br, tbl[i].ov, tbl[i].inv});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].inv ? 1 : 2);
      if (tbl[i].ov || tbl[i].inv) model_cnt++;
      chk($sformatf("tbl%0d_exc_count", i), {16'b0, bus.exc_count}, model_cnt);
    end
    force_inv = 1'b1;
    xact(6'h00, 6'h20, 32'h1, 32'h2, 16'h0, 0, r, g_br, g_ov, g_inv, lat);
    force_inv = 1'b0;
    model_cnt++;
    chk("alu_inv_result", r, 32'h0);
    chk("alu_inv_flags", {29'b0, g_br, g_ov, g_inv}, 32'h1);
    chk("alu_inv_latency", lat, 2);
    chk("alu_inv_exc_count", {16'b0, bus.exc_count}, model_cnt);
    xact(6'h00, 6'h21, 32'h3, 32'h4, 16'h0, 10, r, g_br, g_ov, g_inv, lat);
    chk("bp_result", r, 32'h7);
    chk("bp_ready_after", {31'b0, bus.in_ready}, 32'd1);
    chk("bp_valid_after", {31'b0, bus.out_valid}, 32'd0);
    for (int n = 0; n < 150; n++) begin
      {op, fn} = rops[$urandom_range(0, 18)];
      if (op != 6'h00) fn = 6'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      imm = 16'($urandom);
      ref_model(op, fn, rs, rt, imm, er, e_br, e_ov, e_inv);
      xact(op, fn, rs, rt, imm, $urandom_range(0, 3), r, g_br, g_ov, g_inv, lat);
      chk($sformatf("rnd%0d_result op%h fn%h", n, op, fn), r, er);
      chk($sformatf("rnd%0d_flags op%h fn%h", n, op, fn), {29'b0, g_br, g_ov, g_inv}, {29'b0, e_br, e_ov, e_inv});
      chk($sformatf("rnd%0d_latency", n), lat, e_inv ? 1 : 2);
      if (e_ov || e_inv) model_cnt++;
      chk($sformatf("rnd%0d_exc_count", n), {16'b0, bus.exc_count}, model_cnt);
    end
    bus.in_valid = 1'b1;
    bus.in_opcode = 6'h00; bus.in_funct = 6'h20; bus.in_rs_val = 32'h7FFFFFFF; bus.in_rt_val = 32'h1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("mid_exec_not_valid", {31'b0, bus.out_valid}, 32'd0);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_exc_count", {16'b0, bus.exc_count}, 32'h0);
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_no_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    chk("post_rst_exc_count", {16'b0, bus.exc_count}, model_cnt);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
